lcd_access_arbiter: RTL and testbench

- Shares the single HD44780-style character LCD port (RS, RW, E, 8-bit data) between NUM_REQ requesters, e.g. the button-driven menu FSM and the UART message handler.
- Arbitrates round-robin, with an optional burst lock.
- Sequences each byte transfer with enforced setup, enable-pulse, hold and execution-wait timing.
- Sits between the requesters and the top-level lcd_output pins.

---
 rtl/lcd_arb_pkg.sv | 46 ++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/lcd_access_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_access_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared types, LCD command constants, default timing and init ROM for lcd_access_arbiter.
// ST_INIT and the init ROM are only used when LCD_INIT_SEQ_EN is defined.
package lcd_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_WAIT
`ifdef LCD_INIT_SEQ_EN
        , ST_INIT
`endif
    } state_e;

    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_FUNC_8BIT = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;

    localparam int DEF_T_SETUP_CYC      = 2;
    localparam int DEF_T_E_HIGH_CYC     = 12;
    localparam int DEF_T_HOLD_CYC       = 2;
    localparam int DEF_T_CMD_WAIT_CYC   = 2000;
    localparam int DEF_T_CLEAR_WAIT_CYC = 82000;
    localparam int DEF_T_POWERUP_CYC    = 750000;

    localparam int INIT_LEN = 6;

    // Power-on sequence: 8-bit/2-line x3, display on, clear, entry mode.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = LCD_FUNC_8BIT;
            3'd3:             init_rom = LCD_DISP_ON;
            3'd4:             init_rom = LCD_CLEAR;
            default:          init_rom = LCD_ENTRY;
        endcase
    endfunction

    // Clear and home are the only slow commands of the controller.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        needs_long_wait = !rs && (data == LCD_CLEAR || data == LCD_HOME);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker; a valid lock owner that is still requesting
// overrides the rotation. Search starts at ptr+1.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [IDX_W-1:0]   lock_owner,
    input  logic               lock_valid,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        if (lock_valid && req[lock_owner]) begin
            winner[lock_owner] = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
                if (!found && req[cand]) begin
                    winner[cand] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/lcd_access_arbiter.sv
// Shares one HD44780 write port between NUM_REQ requesters with per-byte timing.
// Define LCD_INIT_SEQ_EN to run the autonomous power-on init sequence after reset.
module lcd_access_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NUM_REQ          = 2,
    parameter int T_SETUP_CYC      = DEF_T_SETUP_CYC,
    parameter int T_E_HIGH_CYC     = DEF_T_E_HIGH_CYC,
    parameter int T_HOLD_CYC       = DEF_T_HOLD_CYC,
    parameter int T_CMD_WAIT_CYC   = DEF_T_CMD_WAIT_CYC,
    parameter int T_CLEAR_WAIT_CYC = DEF_T_CLEAR_WAIT_CYC
`ifdef LCD_INIT_SEQ_EN
    , parameter int T_POWERUP_CYC  = DEF_T_POWERUP_CYC
`endif
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rs,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e,
    output logic [7:0]           lcd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef LCD_INIT_SEQ_EN
    localparam int CNT_MAX = (T_POWERUP_CYC > T_CLEAR_WAIT_CYC) ? T_POWERUP_CYC : T_CLEAR_WAIT_CYC;
`else
    localparam int CNT_MAX = T_CLEAR_WAIT_CYC;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_HIGH_LD = CNT_W'(T_E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD    = CNT_W'(T_CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(T_CLEAR_WAIT_CYC - 1);

    state_e               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d, cnt_dec;
    logic [IDX_W-1:0]     ptr, ptr_d, owner, owner_d, lock_owner, lock_owner_d, win_idx;
    logic                 lock_valid, lock_valid_d;
    logic [NUM_REQ-1:0]   gnt_d, done_d, win_oh;
    logic                 arb_valid, e_d, rs_d, sel_rs;
    logic [7:0]           data_d, sel_data;
`ifdef LCD_INIT_SEQ_EN
    localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(T_POWERUP_CYC - 1);
    logic [2:0] init_idx, init_idx_d;
    logic       in_init;
    assign in_init = (init_idx != 3'(INIT_LEN));
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req),
        .ptr        (ptr),
        .lock_owner (lock_owner),
        .lock_valid (lock_valid),
        .winner     (win_oh),
        .valid      (arb_valid)
    );

    always_comb begin
        win_idx  = '0;
        sel_rs   = 1'b0;
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = IDX_W'(i);
                sel_rs   = req_rs[i];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    assign cnt_dec = cnt - CNT_W'(1);
    assign busy    = (state != ST_IDLE);
    assign lcd_rw  = 1'b0;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        ptr_d        = ptr;
        owner_d      = owner;
        lock_owner_d = lock_owner;
        lock_valid_d = lock_valid;
        gnt_d        = gnt;
        done_d       = '0;
        e_d          = lcd_e;
        rs_d         = lcd_rs;
        data_d       = lcd_data;
`ifdef LCD_INIT_SEQ_EN
        init_idx_d   = init_idx;
`endif
        case (state)
            ST_IDLE: begin
                // A lock owner that stops requesting while idle loses the lock.
                lock_valid_d = lock_valid && req[lock_owner];
                if (arb_valid) begin
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    rs_d    = sel_rs;
                    data_d  = sel_data;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    e_d     = 1'b1;
                    cnt_d   = E_HIGH_LD;
                    state_d = ST_E_HIGH;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_E_HIGH: begin
                if (cnt == '0) begin
                    e_d     = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    cnt_d   = needs_long_wait(lcd_rs, lcd_data) ? CLEAR_LD : CMD_LD;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
                    if (in_init) begin
                        init_idx_d = init_idx + 3'd1;
                        cnt_d      = '0;
                        state_d    = (init_idx == 3'(INIT_LEN - 1)) ? ST_IDLE : ST_INIT;
                    end else begin
`endif
                        done_d       = gnt;
                        gnt_d        = '0;
                        ptr_d        = owner;
                        lock_owner_d = owner;
                        lock_valid_d = req_lock[owner];
                        state_d      = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
                    end
`endif
                end else begin
                    cnt_d = cnt_dec;
                end
            end
`ifdef LCD_INIT_SEQ_EN
            ST_INIT: begin
                if (cnt == '0) begin
                    rs_d    = 1'b0;
                    data_d  = init_rom(init_idx);
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
`ifdef LCD_INIT_SEQ_EN
            state    <= ST_INIT;
            cnt      <= PWR_LD;
            init_idx <= 3'd0;
`else
            state    <= ST_IDLE;
            cnt      <= '0;
`endif
            ptr        <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            lock_owner <= '0;
            lock_valid <= 1'b0;
            gnt        <= '0;
            done       <= '0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
        end else begin
`ifdef LCD_INIT_SEQ_EN
            init_idx <= init_idx_d;
`endif
            state      <= state_d;
            cnt        <= cnt_d;
            ptr        <= ptr_d;
            owner      <= owner_d;
            lock_owner <= lock_owner_d;
            lock_valid <= lock_valid_d;
            gnt        <= gnt_d;
            done       <= done_d;
            lcd_e      <= e_d;
            lcd_rs     <= rs_d;
            lcd_data   <= data_d;
        end
    end

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Directed bench for lcd_access_arbiter with shortened execution waits (cmd 200, clear 3000).
// Expected latencies: gnt->done = 2+12+2+200 = 216 (normal), 2+12+2+3000 = 3016 (clear/home).
module tb_lcd_access_arbiter;

    localparam int LAT_CMD = 216;
    localparam int LAT_CLR = 3016;
    localparam int LIMIT   = 20000;
`ifdef LCD_INIT_SEQ_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [1:0]  req = '0, req_rs = '0, req_lock = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  gnt, done;
    logic        busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Results of the most recent wait_txn call.
    logic [1:0] o_gnt, o_done;
    logic [7:0] o_data;
    logic       o_rs, o_busy, o_stable, o_to;
    int         o_eoff, o_elen, o_lat;

    lcd_access_arbiter #(
        .NUM_REQ          (2),
        .T_SETUP_CYC      (2),
        .T_E_HIGH_CYC     (12),
        .T_HOLD_CYC       (2),
        .T_CMD_WAIT_CYC   (200),
        .T_CLEAR_WAIT_CYC (3000)
`ifdef LCD_INIT_SEQ_EN
        , .T_POWERUP_CYC  (100)
`endif
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .req           (req),
        .req_rs        (req_rs),
        .req_data      (req_data),
        .req_lock      (req_lock),
        .gnt           (gnt),
        .done          (done),
        .busy          (busy),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_e         (lcd_e),
        .lcd_data      (lcd_data)
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    // Waits for a grant, then follows the transaction to its done pulse, returning at that negedge.
    // With drop set, req is released and rs/data scrambled right after the grant.
    task automatic wait_txn(input bit drop);
        int n;
        int tg;
        o_to = 1'b0; o_eoff = -1; o_elen = 0; o_stable = 1'b1;
        o_gnt = '0; o_done = '0; o_lat = 0; o_busy = 1'b1; o_data = 8'h00; o_rs = 1'b0;
        n = 0;
        do begin
            @(negedge clk_clk);
            n++;
        end while (gnt == 2'b00 && n < LIMIT);
        if (gnt == 2'b00) begin
            o_to = 1'b1;
            return;
        end
        o_gnt = gnt; o_data = lcd_data; o_rs = lcd_rs; tg = cyc;
        if (drop) begin
            req      = 2'b00;
            req_rs   = ~req_rs;
            req_data = ~req_data;
        end
        n = 0;
        while (done == 2'b00 && n < LIMIT) begin
            @(negedge clk_clk);
            n++;
            if (lcd_e) begin
                if (o_eoff < 0) o_eoff = cyc - tg;
                o_elen++;
            end
            if (lcd_data !== o_data || lcd_rs !== o_rs || lcd_rw !== 1'b0) o_stable = 1'b0;
        end
        if (done == 2'b00) o_to = 1'b1;
        o_done = done; o_busy = busy; o_lat = cyc - tg;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", gnt); else n_pass++;
        n_checks++; if (done !== 2'b00) $display("FAIL reset_done: got %b expected 00", done); else n_pass++;
        n_checks++; if (busy !== INIT_EN) $display("FAIL reset_busy: got %b expected %b", busy, INIT_EN); else n_pass++;
        n_checks++; if (lcd_e !== 1'b0) $display("FAIL reset_e: got %b expected 0", lcd_e); else n_pass++;
        n_checks++; if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b expected 0", lcd_rs); else n_pass++;
        n_checks++; if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b expected 0", lcd_rw); else n_pass++;
        n_checks++; if (lcd_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", lcd_data); else n_pass++;
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
    endtask

`ifdef LCD_INIT_SEQ_EN
    task automatic test_init();
        logic [7:0] exp_b [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        logic [7:0] got [6];
        int  k = 0;
        int  n = 0;
        bit  prev_e = 1'b0, rs_bad = 1'b0, leak = 1'b0, idle_seen = 1'b0;
        for (int i = 0; i < 6; i++) got[i] = 8'hxx;
        req = 2'b01; req_rs = 2'b01; req_data = 16'h0041; req_lock = 2'b00;
        do_reset();
        while (k < 6 && n < LIMIT) begin
            @(negedge clk_clk);
            n++;
            if (lcd_e && !prev_e) begin
                got[k] = lcd_data;
                if (lcd_rs !== 1'b0) rs_bad = 1'b1;
                k++;
            end
            prev_e = lcd_e;
            if (gnt !== 2'b00 || done !== 2'b00) leak = 1'b1;
            if (busy !== 1'b1) idle_seen = 1'b1;
        end
        n_checks++; if (k != 6) $display("FAIL init_count: got %0d expected 6", k); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== exp_b[i]) $display("FAIL init_byte%0d: got %h expected %h", i, got[i], exp_b[i]);
            else n_pass++;
        end
        n_checks++; if (rs_bad) $display("FAIL init_rs: got 1 expected 0"); else n_pass++;
        n_checks++; if (leak) $display("FAIL init_gnt_done: got activity expected none"); else n_pass++;
        n_checks++; if (idle_seen) $display("FAIL init_busy: got 0 expected 1"); else n_pass++;
        wait_txn(1'b1);
        n_checks++; if (o_gnt !== 2'b01) $display("FAIL init_then_gnt: got %b expected 01", o_gnt); else n_pass++;
        n_checks++; if (o_data !== 8'h41) $display("FAIL init_then_data: got %h expected 41", o_data); else n_pass++;
    endtask
`endif

    task automatic test_single();
        req_rs = 2'b01; req_data = 16'h0041; req_lock = 2'b00; req = 2'b01;
        wait_txn(1'b1);
        n_checks++; if (o_to !== 1'b0) $display("FAIL single_timeout: got 1 expected 0"); else n_pass++;
        n_checks++; if (o_gnt !== 2'b01) $display("FAIL single_gnt: got %b expected 01", o_gnt); else n_pass++;
        n_checks++; if (o_data !== 8'h41) $display("FAIL single_data: got %h expected 41", o_data); else n_pass++;
        n_checks++; if (o_rs !== 1'b1) $display("FAIL single_rs: got %b expected 1", o_rs); else n_pass++;
        n_checks++; if (o_eoff != 2) $display("FAIL single_e_start: got %0d expected 2", o_eoff); else n_pass++;
        n_checks++; if (o_elen != 12) $display("FAIL single_e_width: got %0d expected 12", o_elen); else n_pass++;
        n_checks++; if (o_stable !== 1'b1) $display("FAIL single_stable: got 0 expected 1"); else n_pass++;
        n_checks++; if (o_lat != LAT_CMD) $display("FAIL single_latency: got %0d expected %0d", o_lat, LAT_CMD); else n_pass++;
        n_checks++; if (o_done !== 2'b01) $display("FAIL single_done: got %b expected 01", o_done); else n_pass++;
        n_checks++; if (gnt !== 2'b00) $display("FAIL single_gnt_clear: got %b expected 00", gnt); else n_pass++;
        @(negedge clk_clk);
        n_checks++; if (done !== 2'b00) $display("FAIL single_done_pulse: got %b expected 00", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_clear_cmd();
        logic       rs_t  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] d_t   [4] = '{8'h01, 8'h02, 8'h38, 8'h01};
        int         lat_t [4] = '{LAT_CLR, LAT_CLR, LAT_CMD, LAT_CMD};
        for (int i = 0; i < 4; i++) begin
            req_rs = {rs_t[i], 1'b0}; req_data = {d_t[i], 8'h00}; req_lock = 2'b00; req = 2'b10;
            wait_txn(1'b1);
            n_checks++;
            if (o_gnt !== 2'b10) $display("FAIL clear%0d_gnt: got %b expected 10", i, o_gnt); else n_pass++;
            n_checks++;
            if (o_done !== 2'b10) $display("FAIL clear%0d_done: got %b expected 10", i, o_done); else n_pass++;
            n_checks++;
            if (o_lat != lat_t[i]) $display("FAIL clear%0d_latency: got %0d expected %0d", i, o_lat, lat_t[i]);
            else n_pass++;
        end
        @(negedge clk_clk);
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        req_rs = 2'b11; req_data = 16'h4241; req_lock = 2'b00; req = 2'b11;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_txn(1'b0);
            if (i == 3) req = 2'b00;
            n_checks++;
            if (o_gnt !== exp_g[i]) $display("FAIL rr%0d_gnt: got %b expected %b", i, o_gnt, exp_g[i]); else n_pass++;
            n_checks++;
            if (o_done !== exp_g[i]) $display("FAIL rr%0d_done: got %b expected %b", i, o_done, exp_g[i]); else n_pass++;
            n_checks++;
            if (o_busy !== 1'b0) $display("FAIL rr%0d_idle_gap: got busy %b expected 0", i, o_busy); else n_pass++;
        end
        @(negedge clk_clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rr_stop: got busy %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_burst_lock();
        logic [1:0] exp_g [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
        req_rs = 2'b11; req_data = 16'h3130; req_lock = 2'b10; req = 2'b10;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_txn(1'b0);
            if (i == 0) req = 2'b11;
            if (i == 1) req_lock = 2'b00;
            if (i == 3) req = 2'b00;
            n_checks++;
            if (o_gnt !== exp_g[i]) $display("FAIL lock%0d_gnt: got %b expected %b", i, o_gnt, exp_g[i]); else n_pass++;
        end
        @(negedge clk_clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        req_rs = 2'b01; req_data = 16'h0055; req_lock = 2'b00; req = 2'b01;
        while (lcd_e !== 1'b1 && n < LIMIT) begin
            @(negedge clk_clk);
            n++;
        end
        n_checks++; if (lcd_e !== 1'b1) $display("FAIL midrst_reach_e: got %b expected 1", lcd_e); else n_pass++;
        repeat (3) @(negedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1;
        n_checks++; if (lcd_e !== 1'b0) $display("FAIL midrst_e: got %b expected 0", lcd_e); else n_pass++;
        n_checks++; if (gnt !== 2'b00) $display("FAIL midrst_gnt: got %b expected 00", gnt); else n_pass++;
        n_checks++; if (busy !== INIT_EN) $display("FAIL midrst_busy: got %b expected %b", busy, INIT_EN); else n_pass++;
        n_checks++; if (lcd_data !== 8'h00) $display("FAIL midrst_data: got %h expected 00", lcd_data); else n_pass++;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        wait_txn(1'b1);
        n_checks++; if (o_gnt !== 2'b01) $display("FAIL midrst_regnt: got %b expected 01", o_gnt); else n_pass++;
        n_checks++; if (o_eoff != 2) $display("FAIL midrst_setup: got %0d expected 2", o_eoff); else n_pass++;
        n_checks++; if (o_elen != 12) $display("FAIL midrst_e_width: got %0d expected 12", o_elen); else n_pass++;
        n_checks++; if (o_lat != LAT_CMD) $display("FAIL midrst_latency: got %0d expected %0d", o_lat, LAT_CMD); else n_pass++;
        n_checks++; if (o_data !== 8'h55) $display("FAIL midrst_byte: got %h expected 55", o_data); else n_pass++;
        @(negedge clk_clk);
    endtask

    initial begin
        test_reset();
`ifdef LCD_INIT_SEQ_EN
        test_init();
`endif
        test_single();
        test_clear_cmd();
        test_contention();
        test_burst_lock();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
